// File: rtl/stage1p5_iq_pkg.sv
// Shared constants for the IF->ID instruction queue.
// The bus width is common to IF, the queue and ID.
package stage1p5_iq_pkg;
  localparam int WIDTH_FS_TO_DS_BUS = 64;  // {inst[31:0], pc[31:0]}
endpackage

// File: rtl/stage1p5_iq.sv
// Instruction queue between IF and ID: a circular buffer of {inst, pc} pairs.
// iq_allow_in depends only on registered state, so ds_allow_in has no path back into IF.
module stage1p5_iq
  import stage1p5_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          fs_to_iq_valid,
  input  logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_iq_bus,
  output logic                          iq_allow_in,
  output logic                          iq_to_ds_valid,
  output logic [WIDTH_FS_TO_DS_BUS-1:0] iq_to_ds_bus,
  input  logic                          ds_allow_in,
  input  logic                          iq_flush,
  output logic [AW:0]                   iq_count
);

  localparam logic [AW:0]   CNT_FULL = DEPTH;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH_FS_TO_DS_BUS-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign iq_allow_in    = (count_q != CNT_FULL);
  assign iq_to_ds_valid = (count_q != '0);
  assign iq_to_ds_bus   = mem_q[rd_ptr_q];
  assign iq_count       = count_q;

  assign push = fs_to_iq_valid && iq_allow_in && !iq_flush;
  assign pop  = iq_to_ds_valid && ds_allow_in && !iq_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iq_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head bus reads 0; a flush leaves it untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= fs_to_iq_bus;
    end
  end

endmodule
